// File: rtl/data_mem_arbiter_if.sv
// One requester port of the data memory arbiter: request fields in, completion response out.
interface data_mem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input ack, err, rdata);
  modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter and access sequencer in front of the single-port data memory.
// Each grant runs IDLE -> ACCESS -> DONE; rejected accesses go straight to DONE and never strobe memory.
module data_mem_arbiter #(
  parameter int unsigned ADDR_LIMIT = 65536,
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_arbiter_if.slave p0,
  data_mem_arbiter_if.slave p1,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_read_data,
  output logic              busy,
  output logic              owner,
  output logic [CNT_W-1:0]  p0_count,
  output logic [CNT_W-1:0]  p1_count
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam logic [32:0]      MAX_ADDR = 33'(ADDR_LIMIT) - 33'd4;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic [31:0]      mem_address_q, mem_address_d;
  logic [31:0]      mem_write_data_q, mem_write_data_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             err0_q, err0_d, err1_q, err1_d;
  logic [31:0]      rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic        win;
  logic        sel_we;
  logic        illegal;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [31:0] done_rdata;

  // Round-robin tie-break favours the port that did not win last.
  always_comb begin
    if (p0.req && !p1.req)      win = 1'b0;
    else if (p1.req && !p0.req) win = 1'b1;
    else                        win = FIXED_PRIO ? 1'b0 : ~owner_q;
    sel_we    = win ? p1.we    : p0.we;
    sel_addr  = win ? p1.addr  : p0.addr;
    sel_wdata = win ? p1.wdata : p0.wdata;
    illegal   = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} > MAX_ADDR);
  end

  assign done_rdata = (err_q || we_q) ? '0 : rdata_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d          = state_q;
    owner_d          = owner_q;
    we_d             = we_q;
    err_d            = err_q;
    rdata_d          = rdata_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_read_d       = 1'b0;
    mem_write_d      = 1'b0;
    ack0_d           = 1'b0;
    ack1_d           = 1'b0;
    err0_d           = 1'b0;
    err1_d           = 1'b0;
    rdata0_d         = '0;
    rdata1_d         = '0;
    cnt0_d           = cnt0_q;
    cnt1_d           = cnt1_q;

    unique case (state_q)
      IDLE: begin
        if (p0.req || p1.req) begin
          owner_d = win;
          we_d    = sel_we;
          err_d   = illegal;
          if (illegal) begin
            state_d = DONE;
          end else begin
            state_d          = ACCESS;
            mem_read_d       = ~sel_we;
            mem_write_d      = sel_we;
            mem_address_d    = sel_addr;
            mem_write_data_d = sel_wdata;
          end
        end
      end
      ACCESS: begin
        state_d = DONE;
        rdata_d = we_q ? '0 : mem_read_data;
      end
      DONE: begin
        state_d = IDLE;
        if (owner_q) begin
          ack1_d   = 1'b1;
          err1_d   = err_q;
          rdata1_d = done_rdata;
          if (!err_q && cnt1_q != CNT_MAX) cnt1_d = cnt1_q + 1'b1;
        end else begin
          ack0_d   = 1'b1;
          err0_d   = err_q;
          rdata0_d = done_rdata;
          if (!err_q && cnt0_q != CNT_MAX) cnt0_d = cnt0_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      owner_q          <= 1'b1;
      we_q             <= 1'b0;
      err_q            <= 1'b0;
      rdata_q          <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      ack0_q           <= 1'b0;
      ack1_q           <= 1'b0;
      err0_q           <= 1'b0;
      err1_q           <= 1'b0;
      rdata0_q         <= '0;
      rdata1_q         <= '0;
      cnt0_q           <= '0;
      cnt1_q           <= '0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      we_q             <= we_d;
      err_q            <= err_d;
      rdata_q          <= rdata_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      ack0_q           <= ack0_d;
      ack1_q           <= ack1_d;
      err0_q           <= err0_d;
      err1_q           <= err1_d;
      rdata0_q         <= rdata0_d;
      rdata1_q         <= rdata1_d;
      cnt0_q           <= cnt0_d;
      cnt1_q           <= cnt1_d;
    end
  end

  assign p0.ack         = ack0_q;
  assign p0.err         = err0_q;
  assign p0.rdata       = rdata0_q;
  assign p1.ack         = ack1_q;
  assign p1.err         = err1_q;
  assign p1.rdata       = rdata1_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign busy           = (state_q != IDLE);
  assign owner          = owner_q;
  assign p0_count       = cnt0_q;
  assign p1_count       = cnt1_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: three instances (round-robin, fixed priority, 2-bit counters)
// share one clock/reset; slot s = 2*instance + port.
module tb_data_mem_arbiter;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } txn_t;
  typedef struct { int slot; logic err; logic [31:0] rdata; int lat; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_a   [6] = '{default: 1'b0};
  logic        we_a    [6] = '{default: 1'b0};
  logic [31:0] addr_a  [6] = '{default: 32'h0};
  logic [31:0] wdata_a [6] = '{default: 32'h0};
  logic        ack_a   [6];
  logic        err_a   [6];
  logic [31:0] rdata_a [6];
  logic [15:0] cnt_a   [6];
  logic        mem_read_a  [3];
  logic        mem_write_a [3];
  logic        busy_a      [3];
  logic        owner_a     [3];
  logic [31:0] mem_addr_a  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = (g == 2) ? 2 : 16;
    data_mem_arbiter_if p0_if ();
    data_mem_arbiter_if p1_if ();
    logic [31:0]   mem_address, mem_write_data, mem_read_data;
    logic          mem_read, mem_write, busy, owner;
    logic [CW-1:0] p0_count, p1_count;
    logic [31:0]   mem [0:16383];

    data_mem_arbiter #(.ADDR_LIMIT(65536), .FIXED_PRIO(g == 1), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .p0(p0_if.slave), .p1(p1_if.slave),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
      .busy(busy), .owner(owner), .p0_count(p0_count), .p1_count(p1_count)
    );

    assign p0_if.req   = req_a[2*g];
    assign p0_if.we    = we_a[2*g];
    assign p0_if.addr  = addr_a[2*g];
    assign p0_if.wdata = wdata_a[2*g];
    assign p1_if.req   = req_a[2*g+1];
    assign p1_if.we    = we_a[2*g+1];
    assign p1_if.addr  = addr_a[2*g+1];
    assign p1_if.wdata = wdata_a[2*g+1];
    assign ack_a[2*g]     = p0_if.ack;
    assign err_a[2*g]     = p0_if.err;
    assign rdata_a[2*g]   = p0_if.rdata;
    assign ack_a[2*g+1]   = p1_if.ack;
    assign err_a[2*g+1]   = p1_if.err;
    assign rdata_a[2*g+1] = p1_if.rdata;
    assign cnt_a[2*g]     = 16'(p0_count);
    assign cnt_a[2*g+1]   = 16'(p1_count);
    assign mem_read_a[g]  = mem_read;
    assign mem_write_a[g] = mem_write;
    assign busy_a[g]      = busy;
    assign owner_a[g]     = owner;
    assign mem_addr_a[g]  = mem_address;

    // Word k of every memory initially holds 0xA500_0000 | k.
    initial for (int k = 0; k < 16384; k++) mem[k] <= 32'hA500_0000 | 32'(k);
    always @(posedge clk) if (mem_write) mem[mem_address[15:2]] <= mem_write_data;
    assign mem_read_data = mem_read ? mem[mem_address[15:2]] : 32'h0;
  end

  txn_t pend [6][$];
  exp_t sb[$];
  int   start_cyc [6] = '{default: 0};
  int   wr_cyc [3] = '{default: 0};
  int   rd_cyc [3] = '{default: 0};
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input int slot, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                       input int lat, input bit expect_ack = 1'b1);
    txn_t t;
    exp_t e;
    t.we = we; t.addr = addr; t.wdata = wdata;
    pend[slot].push_back(t);
    if (expect_ack) begin
      e.slot = slot; e.err = err; e.rdata = rdata; e.lat = lat;
      sb.push_back(e);
    end
  endtask

  function automatic bit pend_empty();
    for (int s = 0; s < 6; s++) if (pend[s].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain();
    bit done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk);
      done = (sb.size() == 0) && pend_empty();
    end
    check("drain_timeout", 32'(done), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor then requester model, both on the falling edge away from DUT updates.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (mem_write_a[i]) wr_cyc[i]++;
      if (mem_read_a[i])  rd_cyc[i]++;
    end
    for (int s = 0; s < 6; s++) begin
      if (ack_a[s]) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: slot %0d acked, expected no ack", s);
        end else begin
          e = sb.pop_front();
          check("ack_slot", 32'(s), 32'(e.slot));
          check("ack_err", 32'(err_a[s]), 32'(e.err));
          check("ack_rdata", rdata_a[s], e.rdata);
          if (e.lat != 0) check("ack_latency", 32'(cyc - start_cyc[s]), 32'(e.lat));
        end
      end
      if (rst) begin
        pend[s].delete();
        req_a[s] = 1'b0;
      end else begin
        if (ack_a[s] && pend[s].size() > 0) begin
          pend[s].delete(0);
          req_a[s] = 1'b0;
        end
        if (!req_a[s] && pend[s].size() > 0) begin
          req_a[s]     = 1'b1;
          we_a[s]      = pend[s][0].we;
          addr_a[s]    = pend[s][0].addr;
          wdata_a[s]   = pend[s][0].wdata;
          start_cyc[s] = cyc;
        end
      end
    end
  end

  initial begin
    int  w0, r0;
    bit  seen;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy%0d", i), 32'(busy_a[i]), 32'd0);
      check($sformatf("rst_owner%0d", i), 32'(owner_a[i]), 32'd1);
      check($sformatf("rst_mem_read%0d", i), 32'(mem_read_a[i]), 32'd0);
      check($sformatf("rst_mem_write%0d", i), 32'(mem_write_a[i]), 32'd0);
      check($sformatf("rst_mem_addr%0d", i), mem_addr_a[i], 32'd0);
    end
    for (int s = 0; s < 6; s++) begin
      check($sformatf("rst_ack%0d", s), 32'(ack_a[s]), 32'd0);
      check($sformatf("rst_rdata%0d", s), rdata_a[s], 32'd0);
      check($sformatf("rst_count%0d", s), 32'(cnt_a[s]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Write then read back on port 0.
    w0 = wr_cyc[0]; r0 = rd_cyc[0];
    issue(0, 1'b1, 32'd2000, 32'hDEADBEEF, 1'b0, 32'h0, 3);
    issue(0, 1'b0, 32'd2000, 32'h0, 1'b0, 32'hDEADBEEF, 3);
    drain();
    check("t1_write_cycles", 32'(wr_cyc[0] - w0), 32'd1);
    check("t1_read_cycles", 32'(rd_cyc[0] - r0), 32'd1);
    check("t1_p0_count", 32'(cnt_a[0]), 32'd2);
    check("t1_p1_count", 32'(cnt_a[1]), 32'd0);

    // Reset while a write is in ACCESS.
    issue(0, 1'b1, 32'h100, 32'h12345678, 1'b0, 32'h0, 0, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = mem_write_a[0];
    end
    check("t5_write_started", 32'(seen), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_mem_write_drop", 32'(mem_write_a[0]), 32'd0);
    check("t5_busy", 32'(busy_a[0]), 32'd0);
    check("t5_owner", 32'(owner_a[0]), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t5_p0_count", 32'(cnt_a[0]), 32'd0);
    check("t5_p1_count", 32'(cnt_a[1]), 32'd0);
    check("t5_idle", 32'(busy_a[0]), 32'd0);

    // Simultaneous reads after reset: port 0 first, port 1 three cycles later.
    issue(0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hA500_0010, 3);
    issue(1, 1'b0, 32'h80, 32'h0, 1'b0, 32'hA500_0020, 6);
    drain();
    check("t2_owner", 32'(owner_a[0]), 32'd1);
    check("t2_p0_count", 32'(cnt_a[0]), 32'd1);
    check("t2_p1_count", 32'(cnt_a[1]), 32'd1);

    // Rejected accesses on port 1, then the last legal word.
    w0 = wr_cyc[0]; r0 = rd_cyc[0];
    issue(1, 1'b0, 32'd2001, 32'h0, 1'b1, 32'h0, 2);
    issue(1, 1'b0, 32'd65533, 32'h0, 1'b1, 32'h0, 2);
    issue(1, 1'b1, 32'd65536, 32'hFFFF_FFFF, 1'b1, 32'h0, 2);
    drain();
    check("t4_no_write", 32'(wr_cyc[0] - w0), 32'd0);
    check("t4_no_read", 32'(rd_cyc[0] - r0), 32'd0);
    check("t4_p1_count", 32'(cnt_a[1]), 32'd1);
    issue(1, 1'b0, 32'd65532, 32'h0, 1'b0, 32'hA500_3FFF, 3);
    drain();
    check("t4_p1_count_legal", 32'(cnt_a[1]), 32'd2);

    // Both ports holding requests: round-robin alternates starting with port 0.
    issue(0, 1'b0, 32'h00, 32'h0, 1'b0, 32'hA500_0000, 0);
    issue(1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hA500_0004, 0);
    issue(0, 1'b0, 32'h04, 32'h0, 1'b0, 32'hA500_0001, 0);
    issue(1, 1'b0, 32'h14, 32'h0, 1'b0, 32'hA500_0005, 0);
    issue(0, 1'b0, 32'h08, 32'h0, 1'b0, 32'hA500_0002, 0);
    issue(1, 1'b0, 32'h18, 32'h0, 1'b0, 32'hA500_0006, 0);
    drain();
    check("t3_rr_p0_count", 32'(cnt_a[0]), 32'd4);
    check("t3_rr_p1_count", 32'(cnt_a[1]), 32'd5);

    // Fixed priority: port 0 takes all six before port 1 is served.
    for (int k = 0; k < 6; k++)
      issue(2, 1'b0, 32'(4 * k), 32'h0, 1'b0, 32'hA500_0000 | 32'(k), 0);
    issue(3, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA500_0008, 0);
    drain();
    check("t3_fp_p0_count", 32'(cnt_a[2]), 32'd6);
    check("t3_fp_p1_count", 32'(cnt_a[3]), 32'd1);

    // 2-bit counter saturates at 3.
    for (int k = 0; k < 5; k++)
      issue(4, 1'b0, 32'(4 * k), 32'h0, 1'b0, 32'hA500_0000 | 32'(k), 3);
    drain();
    check("t6_p0_count_sat", 32'(cnt_a[4]), 32'd3);
    check("t6_p1_count", 32'(cnt_a[5]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
